// File: rtl/unibus_master_if.sv
// unibus_master_if: host request/response and Unibus master-side signals for unibus_master.
interface unibus_master_if;
   logic        req_start;
   logic [17:0] req_addr;
   logic        req_write;
   logic        req_byte;
   logic [15:0] req_wdata;
   logic        busy;
   logic        done;
   logic        nxm;
   logic [15:0] rdata;
   logic [17:0] a_out_h;
   logic [1:0]  c_out_h;
   logic [15:0] d_out_h;
   logic        msyn_out_h;
   logic        ssyn_in_h;
   logic [15:0] d_in_h;
   modport master (
      input  req_start, req_addr, req_write, req_byte, req_wdata, ssyn_in_h, d_in_h,
      output busy, done, nxm, rdata, a_out_h, c_out_h, d_out_h, msyn_out_h
   );
   modport slave (
      output req_start, req_addr, req_write, req_byte, req_wdata, ssyn_in_h, d_in_h,
      input  busy, done, nxm, rdata, a_out_h, c_out_h, d_out_h, msyn_out_h
   );
endinterface

// File: rtl/unibus_master.sv
// unibus_master: runs one DATI/DATO/DATOB Unibus cycle per host request.
// UNIBUS_MASTER_TIMEOUT_EN enables the NXM timeout; otherwise MSYN waits for SSYN forever.
module unibus_master #(
   parameter int DESKEW  = 15,
   parameter int HOLD    = 10,
   parameter int TIMEOUT = 1000
) (
   input logic             clk,
   input logic             rst,
   unibus_master_if.master bus
);
   localparam logic [15:0] C_DESKEW  = (DESKEW == 0) ? 16'd1 : 16'(DESKEW);
   localparam logic [15:0] C_HOLD    = (HOLD == 0) ? 16'd1 : 16'(HOLD);
   localparam logic [15:0] C_TIMEOUT = (TIMEOUT == 0) ? 16'd1 : 16'(TIMEOUT);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_MSYN, S_RELEASE, S_HOLD, S_DONE} state_t;
   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_nxm;
   logic [15:0] r_rdata;
   logic [17:0] r_a;
   logic [1:0]  r_c;
   logic [15:0] r_d;
   logic        r_msyn;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.nxm        = r_nxm;
   assign bus.rdata      = r_rdata;
   assign bus.a_out_h    = r_a;
   assign bus.c_out_h    = r_c;
   assign bus.d_out_h    = r_d;
   assign bus.msyn_out_h = r_msyn;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_nxm   <= 1'b0;
         r_rdata <= '0;
         r_a     <= '0;
         r_c     <= '0;
         r_d     <= '0;
         r_msyn  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.req_start) begin
                  r_busy  <= 1'b1;
                  r_a     <= bus.req_addr;
                  r_c     <= bus.req_write ? {1'b1, bus.req_byte} : 2'b00;
                  r_d     <= bus.req_write ? bus.req_wdata : 16'd0;
                  r_cnt   <= C_DESKEW;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               // a slave still holding SSYN from a previous cycle restarts the deskew
               if (bus.ssyn_in_h) r_cnt <= C_DESKEW;
               else if (r_cnt == 16'd0) begin
                  r_msyn  <= 1'b1;
                  r_cnt   <= C_TIMEOUT;
                  r_state <= S_MSYN;
               end else r_cnt <= r_cnt - 16'd1;
            end
            S_MSYN: begin
               if (bus.ssyn_in_h) begin
                  if (!r_c[1]) r_rdata <= bus.d_in_h;
                  r_msyn  <= 1'b0;
                  r_nxm   <= 1'b0;
                  r_state <= S_RELEASE;
               end
`ifdef UNIBUS_MASTER_TIMEOUT_EN
               else if (r_cnt <= 16'd1) begin
                  r_msyn  <= 1'b0;
                  r_nxm   <= 1'b1;
                  r_rdata <= '0;
                  r_cnt   <= C_HOLD;
                  r_state <= S_HOLD;
               end else r_cnt <= r_cnt - 16'd1;
`endif
            end
            S_RELEASE: begin
               if (!bus.ssyn_in_h) begin
                  r_cnt   <= C_HOLD;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_cnt == 16'd0) begin
                  r_a     <= '0;
                  r_c     <= '0;
                  r_d     <= '0;
                  r_state <= S_DONE;
               end else r_cnt <= r_cnt - 16'd1;
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_unibus_master.sv
// tb_unibus_master: vector table plus scoreboard against an M9312 ROM and RAM stub.
module tb_unibus_master;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   unibus_master_if bus();
   unibus_master #(.DESKEW(15), .HOLD(10), .TIMEOUT(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_chk = 0;
   int n_pass = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0o want %0o", name, act, exp);
   endtask
   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
   endtask
   // slave side: M9312 ROM at 765000 (20-cycle ack), RAM at 001000 (3-cycle ack)
   logic [15:0] ram [0:255];
   logic        r_ssyn = 1'b0;
   logic [15:0] r_din = '0;
   logic        stuck = 1'b0;
   int          scnt = 0;
   assign bus.ssyn_in_h = r_ssyn | stuck;
   assign bus.d_in_h = r_din;
   function automatic logic [15:0] rom(input logic [8:0] off);
      case (off)
         9'o000:  return 16'o165000;
         9'o004:  return 16'o100000;
         9'o776:  return 16'o123162;
         default: return {7'd0, off};
      endcase
   endfunction
   always @(posedge clk) begin
      if (rst || !bus.msyn_out_h) begin
         r_ssyn <= 1'b0;
         scnt <= 0;
      end else if (!r_ssyn) begin
         scnt <= scnt + 1;
         if (bus.a_out_h[17:9] == 9'o765 && scnt + 1 == 20) begin
            r_ssyn <= 1'b1;
            r_din <= rom(bus.a_out_h[8:0]);
         end else if (bus.a_out_h[17:9] == 9'o001 && scnt + 1 == 3) begin
            r_ssyn <= 1'b1;
            if (!bus.c_out_h[1]) r_din <= ram[bus.a_out_h[8:1]];
            else if (!bus.c_out_h[0]) ram[bus.a_out_h[8:1]] <= bus.d_out_h;
            else if (bus.a_out_h[0]) ram[bus.a_out_h[8:1]][15:8] <= bus.d_out_h[15:8];
            else ram[bus.a_out_h[8:1]][7:0] <= bus.d_out_h[7:0];
         end
      end
   end
   // monitors
   logic [17:0] ex_a = '0;
   logic [1:0]  ex_c = '0;
   logic [15:0] ex_d = '0;
   logic [17:0] cap_a;
   logic [1:0]  cap_c;
   logic [15:0] cap_d;
   int hi_cnt = 0, last_w = 0, done_cnt = 0, viol = 0;
   always @(negedge clk) begin
      if (bus.msyn_out_h) begin
         hi_cnt <= hi_cnt + 1;
         cap_a <= bus.a_out_h;
         cap_c <= bus.c_out_h;
         cap_d <= bus.d_out_h;
      end else if (hi_cnt != 0) begin
         last_w <= hi_cnt;
         hi_cnt <= 0;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.busy && bus.a_out_h != 0 && (bus.a_out_h != ex_a || bus.c_out_h != ex_c || bus.d_out_h != ex_d))
         viol <= viol + 1;
      if (!bus.busy && bus.msyn_out_h) viol <= viol + 1;
   end
   task automatic start(input logic [17:0] a, input logic w, input logic b, input logic [15:0] wd);
      ex_a = a;
      ex_c = w ? {1'b1, b} : 2'b00;
      ex_d = w ? wd : 16'd0;
      bus.req_addr = a;
      bus.req_write = w;
      bus.req_byte = b;
      bus.req_wdata = wd;
      bus.req_start = 1'b1;
      @(posedge clk);
      #1;
      bus.req_start = 1'b0;
      chk("busy_on_accept", {31'd0, bus.busy}, 1);
      chk("addr_on_accept", {14'd0, bus.a_out_h}, {14'd0, a});
   endtask
   task automatic wait_done(input int lim);
      for (int i = 0; i < lim && bus.done !== 1'b1; i++) @(negedge clk);
      chk("done_seen", {31'd0, bus.done}, 1);
   endtask
   task automatic chk_idle(input string name);
      chk({name, "_busy"}, {31'd0, bus.busy}, 0);
      chk({name, "_done"}, {31'd0, bus.done}, 0);
      chk({name, "_nxm"}, {31'd0, bus.nxm}, 0);
      chk({name, "_rdata"}, {16'd0, bus.rdata}, 0);
      chk({name, "_a"}, {14'd0, bus.a_out_h}, 0);
      chk({name, "_c"}, {30'd0, bus.c_out_h}, 0);
      chk({name, "_d"}, {16'd0, bus.d_out_h}, 0);
      chk({name, "_msyn"}, {31'd0, bus.msyn_out_h}, 0);
   endtask
   typedef struct {
      logic [17:0] a;
      logic        w;
      logic        b;
      logic [15:0] wd;
      logic [15:0] rd;
      logic        rdv;
      logic [1:0]  c;
      int          wlo;
      int          whi;
   } vec_t;
   typedef struct {
      logic [15:0] rd;
      logic        nxm;
      logic        rdv;
   } exp_t;
   vec_t vecs [7];
   exp_t sb [$];
   exp_t e;
   vec_t v;
   int d0, v0, lows, edges;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vecs[0] = '{18'o765000, 1'b0, 1'b0, 16'o0,      16'o165000, 1'b1, 2'b00, 20, 21};
      vecs[1] = '{18'o765776, 1'b0, 1'b0, 16'o0,      16'o123162, 1'b1, 2'b00, 20, 21};
      vecs[2] = '{18'o765004, 1'b0, 1'b0, 16'o0,      16'o100000, 1'b1, 2'b00, 20, 21};
      vecs[3] = '{18'o001000, 1'b1, 1'b0, 16'o052525, 16'o0,      1'b0, 2'b10, 4, 4};
      vecs[4] = '{18'o001000, 1'b0, 1'b0, 16'o0,      16'o052525, 1'b1, 2'b00, 4, 4};
      vecs[5] = '{18'o001001, 1'b1, 1'b1, 16'o077400, 16'o0,      1'b0, 2'b11, 4, 4};
      vecs[6] = '{18'o001000, 1'b0, 1'b0, 16'o0,      16'o077525, 1'b1, 2'b00, 4, 4};
      bus.req_start = 1'b0;
      bus.req_addr = '0;
      bus.req_write = 1'b0;
      bus.req_byte = 1'b0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         d0 = done_cnt;
         v0 = viol;
         sb.push_back('{v.rd, 1'b0, v.rdv});
         start(v.a, v.w, v.b, v.wd);
         wait_done(3000);
         e = sb.pop_front();
         if (e.rdv) chk($sformatf("rdata_%0d", i), {16'd0, bus.rdata}, {16'd0, e.rd});
         chk($sformatf("nxm_%0d", i), {31'd0, bus.nxm}, {31'd0, e.nxm});
         chk($sformatf("c_out_%0d", i), {30'd0, cap_c}, {30'd0, v.c});
         chk($sformatf("a_out_%0d", i), {14'd0, cap_a}, {14'd0, v.a});
         chk($sformatf("d_out_%0d", i), {16'd0, cap_d}, {16'd0, ex_d});
         chk_rng($sformatf("msyn_width_%0d", i), last_w, v.wlo, v.whi);
         chk($sformatf("msyn_low_at_done_%0d", i), {31'd0, bus.msyn_out_h}, 0);
         @(negedge clk);
         chk($sformatf("done_once_%0d", i), done_cnt - d0, 1);
         chk($sformatf("done_pulse_%0d", i), {31'd0, bus.done}, 0);
         chk($sformatf("bus_stable_%0d", i), viol - v0, 0);
      end
      // non-existent memory
`ifdef UNIBUS_MASTER_TIMEOUT_EN
      sb.push_back('{16'd0, 1'b1, 1'b1});
      start(18'o160000, 1'b0, 1'b0, 16'd0);
      wait_done(3000);
      e = sb.pop_front();
      chk("nxm_flag", {31'd0, bus.nxm}, {31'd0, e.nxm});
      chk("nxm_rdata", {16'd0, bus.rdata}, {16'd0, e.rd});
      chk("nxm_msyn_width", last_w, 1000);
      @(negedge clk);
`else
      start(18'o160000, 1'b0, 1'b0, 16'd0);
      lows = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (!bus.busy || bus.nxm) lows++;
      end
      chk("nxm_busy_forever", lows, 0);
      chk("nxm_msyn_still_high", {31'd0, bus.msyn_out_h}, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
`endif
      // lingering SSYN delays MSYN
      stuck = 1'b1;
      start(18'o765000, 1'b0, 1'b0, 16'd0);
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.msyn_out_h) lows++;
      end
      chk("stuck_msyn_held_low", lows, 0);
      @(posedge clk);
      #1;
      stuck = 1'b0;
      edges = 0;
      while (!bus.msyn_out_h && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk("stuck_deskew_edges", edges, 16);
      wait_done(3000);
      chk("stuck_rdata", {16'd0, bus.rdata}, 32'o165000);
      @(negedge clk);
      // reset while MSYN is asserted
      start(18'o765000, 1'b0, 1'b0, 16'd0);
      for (int i = 0; i < 100 && !bus.msyn_out_h; i++) @(negedge clk);
      chk("rst_reached_msyn", {31'd0, bus.msyn_out_h}, 1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_idle("midreset");
      rst = 1'b0;
      d0 = done_cnt;
      repeat (60) @(negedge clk);
      chk("midreset_no_done", done_cnt - d0, 0);
      start(18'o765776, 1'b0, 1'b0, 16'd0);
      wait_done(3000);
      chk("post_reset_rdata", {16'd0, bus.rdata}, 32'o123162);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/unibus_master.md
# unibus_master

Unibus bus-master cycle engine: turns a single host request into a full Unibus DATI, DATO or DATOB cycle. It drives address, control and write data, sequences MSYN against the slave's SSYN, and returns read data or a non-existent-memory (NXM) timeout. It sits between CPU/DMA-side logic and the simulated Unibus, opposite slaves such as the boot ROM card. Bus arbitration (BR/NPR/BBSY) is out of scope; the block assumes it already owns the bus.

## Interface
- DESKEW, 15: cycles that address/data/control must be stable, with SSYN low, before MSYN rises (150 ns at 100 MHz).
- HOLD, 10: cycles that address/control are held after SSYN drops.
- TIMEOUT, 1000: cycles of MSYN without SSYN before NXM (10 µs).
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- req_start  in  1  start pulse; sampled only in IDLE.
- req_addr  in  18  byte address.
- req_write  in  1  1 = DATO/DATOB, 0 = DATI.
- req_byte  in  1  with req_write, 1 = DATOB.
- req_wdata  in  16  write data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- nxm  out  1  valid with done; 1 = timeout.
- rdata  out  16  read data; valid with done and held until the next accept.
- a_out_h  out  18  bus address.
- c_out_h  out  2  C1,C0: 00 DATI, 10 DATO, 11 DATOB.
- d_out_h  out  16  bus write data (0 when not writing).
- msyn_out_h  out  1  master sync.
- ssyn_in_h  in  1  slave sync.
- d_in_h  in  16  bus read data.

## Operation
- States: IDLE, SETUP, MSYN, RELEASE, HOLD, DONE.
- IDLE: all bus outputs 0; busy 0.
  - When req_start = 1, latch addr, control and data; for DATO/DATOB drive d_out_h = req_wdata.
  - Load the deskew counter; go to SETUP.
- SETUP:
  - Bus outputs are driven.
  - Decrement the counter only while ssyn_in_h = 0; if SSYN is high, reload the counter, so a lingering slave SSYN delays MSYN.
  - When the counter reaches 0, set msyn_out_h and load the timeout counter; go to MSYN.
- MSYN:
  - First cycle ssyn_in_h = 1: for DATI, latch rdata ← d_in_h at that edge. Clear msyn_out_h and nxm; go to RELEASE.
  - Timeout counter reaches 0 with SSYN still low: clear msyn_out_h, set nxm, rdata ← 0; go to HOLD.
- RELEASE: wait for ssyn_in_h = 0, with no timeout. Then load the hold counter; go to HOLD.
- HOLD: count HOLD cycles with address, control and data still driven. Then zero all bus outputs; go to DONE.
- DONE: done = 1 for one cycle; go to IDLE. A req_start in DONE is ignored; a start is accepted only in IDLE.
- Counters are wide enough for TIMEOUT (at least 16 bits). A value of 0 for any parameter behaves as 1.
- req_byte is ignored when req_write = 0. DATIP is never generated.

## Timing
- Reset values: busy 0, done 0, nxm 0, rdata 0, a_out_h 0, c_out_h 0, d_out_h 0, msyn_out_h 0; state IDLE.
- RESET mid-cycle: the next edge forces reset values; MSYN drops immediately and no done is issued.
- req_start at edge N: bus outputs valid and busy = 1 after edge N.
- msyn_out_h rises at edge N+DESKEW+1, assuming SSYN stays low.
- Slave asserts SSYN k cycles after MSYN: msyn_out_h falls one edge later; rdata latched at that same edge.
- done pulse occurs HOLD+2 edges after SSYN is seen low.
- NXM: msyn_out_h is high exactly TIMEOUT cycles.

## Configuration
- UNIBUS_MASTER_TIMEOUT_EN defined: NXM timeout as described.
- UNIBUS_MASTER_TIMEOUT_EN undefined:
  - The MSYN state waits forever for SSYN; nxm is tied to 0.
  - The TIMEOUT parameter is accepted but unused.

## Test plan
- DATI to an M9312 model at 765000: rdata = 165000, nxm = 0, c_out_h = 00, MSYN high 20–21 cycles (slave delay), done once.
- DATI at 765776 → rdata = 123162; back-to-back DATI at 765004 → 100000, with no MSYN overlap and a_out_h stable from SETUP through HOLD.
- DATO 001000 ← 052525 to a RAM stub that acks after 3 cycles:
  - c_out_h = 10 and d_out_h = 052525 held until HOLD ends.
  - RAM reads back 052525.
- DATOB at 001001 with data 177 → c_out_h = 11, a_out_h[0] = 1.
- No responder at 160000 with TIMEOUT = 1000:
  - MSYN high exactly 1000 cycles; done with nxm = 1, rdata = 0.
  - With the macro undefined, busy stays high indefinitely.
- Stuck SSYN held high at start: MSYN stays low until SSYN drops, then DESKEW cycles follow. RESET asserted while in MSYN → all outputs 0 the next cycle and no done.
